// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, memory address, in-order fetch buffer
// Handles redirects, address-range faults and the end-of-program marker.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] INST_BASE  = 32'h0000_3000,
  parameter logic [31:0] INST_LIMIT = 32'h0000_3FFC,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] EOF_WORD   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault,
  output logic        halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   buf_pc_q [DEPTH];
  logic [31:0]   buf_pc_d [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fault_q, fault_d;
  logic          halted_q, halted_d;

  logic pc_legal;
  logic pop;
  logic attempt;
  logic push;

  assign inst_addr   = pc_q;
  assign out_valid   = (count_q != '0) && !redirect_valid;
  assign out_pc      = buf_pc_q[rd_ptr_q];
  assign out_instr   = buf_instr_q[rd_ptr_q];
  assign fetch_fault = fault_q;
  assign halted      = halted_q;

  // A pop frees a slot in the same cycle, so a full buffer still fetches while draining.
  always_comb begin
    pc_legal = (pc_q >= INST_BASE) && (pc_q <= INST_LIMIT) && (pc_q[1:0] == 2'b00);
    pop      = out_valid && out_ready;
    attempt  = !redirect_valid && !fault_q && !halted_q && ((count_q < DEPTH_C) || pop);
    push     = attempt && pc_legal && (instr != EOF_WORD);
  end

  always_comb begin
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    fault_d     = fault_q;
    halted_d    = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      fault_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (attempt && !pc_legal) begin
        fault_d = 1'b1;
      end else if (attempt && (instr == EOF_WORD)) begin
        halted_d = 1'b1;
      end
      if (push) begin
        buf_pc_d[wr_ptr_q]    = pc_q;
        buf_instr_d[wr_ptr_q] = instr;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        pc_d                  = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      halted_q <= halted_d;
    end
  end

  // Entry storage carries no reset; contents are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit
// Queue-based reference model compared every cycle, plus literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] INST_BASE  = 32'h0000_3000;
  localparam logic [31:0] INST_LIMIT = 32'h0000_3FFC;
  localparam int          DEPTH      = 4;
  localparam logic [31:0] EOF_WORD   = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;
  logic        halted;

  int tests = 0;
  int fails = 0;

  fetch_unit #(
    .RESET_PC(RESET_PC), .INST_BASE(INST_BASE), .INST_LIMIT(INST_LIMIT),
    .DEPTH(DEPTH), .EOF_WORD(EOF_WORD)
  ) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .instr(instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 1024 words at 0x3000..0x3FFC, address-derived filler elsewhere.
  logic [31:0] mem [1024];
  logic [31:0] off;
  assign off = inst_addr - INST_BASE;
  always_comb begin
    if ((inst_addr >= INST_BASE) && (inst_addr <= INST_LIMIT)) instr = mem[off[11:2]];
    else instr = inst_addr ^ 32'h5A5A_1234;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] o;
    o = a - INST_BASE;
    if ((a >= INST_BASE) && (a <= INST_LIMIT)) return mem[o[11:2]];
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic bit is_legal(input logic [31:0] a);
    return (a >= INST_BASE) && (a <= INST_LIMIT) && (a[1:0] == 2'b00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of fetched {pc, instr} pairs plus PC and sticky flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_halted;
  bit          model_valid = 0;
  bit          m_pop;
  bit          m_try;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pc        = RESET_PC;
      m_fault     = 0;
      m_halted    = 0;
      model_valid = 1;
    end else if (model_valid) begin
      if (redirect_valid) begin
        q.delete();
        m_pc     = redirect_pc;
        m_fault  = 0;
        m_halted = 0;
      end else begin
        m_pop  = (q.size() > 0) && out_ready;
        m_try  = !m_fault && !m_halted && ((q.size() < DEPTH) || m_pop);
        m_word = word_at(m_pc);
        if (m_pop) void'(q.pop_front());
        if (m_try) begin
          if (!is_legal(m_pc)) m_fault = 1;
          else if (m_word == EOF_WORD) m_halted = 1;
          else begin
            q.push_back('{pc: m_pc, ins: m_word});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("inst_addr", inst_addr, m_pc);
      chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0) && !redirect_valid});
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      chk("halted", {31'b0, halted}, {31'b0, m_halted});
      if (out_valid && q.size() != 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].ins);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i] == EOF_WORD) mem[i] = 32'h0;
    end
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
  endtask

  logic [31:0] tgt;
  int          sel;

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    fill_mem();

    // Reset release with the first three words streaming out.
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inst_addr", inst_addr, 32'h3000);
    rst = 1'b0;
    tick();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'h3000);
    chk("first_instr", out_instr, 32'h1111_1111);
    tick();
    chk("second_pc", out_pc, 32'h3004);
    chk("second_instr", out_instr, 32'h2222_2222);
    tick();
    chk("third_pc", out_pc, 32'h3008);
    chk("third_instr", out_instr, 32'h3333_3333);

    // Backpressure: fill, stall, then drain with no gap.
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_addr_hold", inst_addr, 32'h3010);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_pc", out_pc, 32'h3000 + 32'(4 * k));
      tick();
    end

    // Redirect while three entries are buffered.
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h3020; out_ready = 1'b1;
    #1;
    chk("redir_no_pop", {31'b0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("redir_empty", {31'b0, out_valid}, 32'd0);
    tick();
    chk("redir_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_pc", out_pc, 32'h3020);

    // Misaligned redirect faults; a legal redirect clears it.
    redirect_valid = 1'b1; redirect_pc = 32'h3002;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("misalign_fault", {31'b0, fetch_fault}, 32'd1);
    chk("misalign_novalid", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect_valid = 1'b0;
    chk("fault_cleared", {31'b0, fetch_fault}, 32'd0);
    tick();
    chk("resume_pc", out_pc, 32'h3000);

    // Run off the end of the instruction range.
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h3FF8;
    tick();
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    chk("end_fault", {31'b0, fetch_fault}, 32'd1);
    chk("end_head", out_pc, 32'h3FF8);
    out_ready = 1'b1;
    tick();
    chk("end_drain", out_pc, 32'h3FFC);
    tick();
    chk("end_empty", {31'b0, out_valid}, 32'd0);

    // End-of-program marker at 0x3008, then reset mid-run.
    mem[2] = EOF_WORD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("eof_halted", {31'b0, halted}, 32'd1);
    chk("eof_addr", inst_addr, 32'h3008);
    rst = 1'b1;
    tick();
    chk("eof_rst_halted", {31'b0, halted}, 32'd0);
    chk("eof_rst_addr", inst_addr, 32'h3000);
    rst = 1'b0;

    // Randomized phase with sparse EOF markers, redirects and resets.
    fill_mem();
    for (int i = 0; i < 6; i++) mem[$urandom_range(8, 1023)] = EOF_WORD;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      out_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 99) < 5);
      sel = $urandom_range(0, 9);
      if (sel < 6)       tgt = 32'h3000 + ($urandom_range(0, 1023) << 2);
      else if (sel < 8)  tgt = 32'h3FF0 + ($urandom_range(0, 3) << 2);
      else if (sel == 8) tgt = 32'h3000 + $urandom_range(0, 4095);
      else               tgt = ($urandom_range(0, 1) != 0) ? 32'h2FFC : 32'h4000;
      redirect_pc = tgt;
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the integrated instruction/data memory's instruction port. It owns the program counter, drives the word address into memory, and captures the combinationally returned instruction word. Captured words go into a small in-order buffer that decode drains through a valid/ready handshake. It also handles control-flow redirects, address-range faults and the end-of-program marker.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `INST_BASE`, 32'h0000_3000, lowest legal instruction address.
- `INST_LIMIT`, 32'h0000_3FFC, highest legal instruction address.
- `DEPTH`, 4, fetch buffer entries (power of two, ≥2).
- `EOF_WORD`, 32'hFFFF_FFFF, end-of-program marker.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `inst_addr`  out  32  byte address to memory; always equals PC.
- `instr`  in  32  instruction word from memory, valid in the same cycle as `inst_addr`.
- `redirect_valid`  in  1  branch/jump redirect request.
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  buffer head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head PC.
- `fetch_fault`  out  1  sticky: PC was illegal when a fetch was attempted.
- `halted`  out  1  sticky: `EOF_WORD` was fetched.

## Operation
- State: `pc`, circular buffer (`DEPTH` entries of {pc, instr}), rd/wr pointers, occupancy `count` (0..`DEPTH`), `fetch_fault`, `halted`.
- PC is legal when `INST_BASE` ≤ pc ≤ `INST_LIMIT` and pc[1:0] = 0.
- Pop: `out_valid && out_ready`.
- A fetch is attempted when all of the following hold:
  - `redirect_valid` is 0.
  - `fetch_fault` and `halted` are both 0.
  - `count < DEPTH`, or a pop occurs this cycle.
- Attempted fetch with an illegal PC:
  - Set `fetch_fault`.
  - No push; PC holds.
- Attempted fetch with a legal PC, `instr == EOF_WORD`:
  - Set `halted`.
  - No push; PC holds.
- Attempted fetch, any other case:
  - Push {pc, instr}.
  - pc ← pc + 4, modulo 2^32, no saturation.
  - The next fetch then faults if the new PC exceeds `INST_LIMIT`.
- Redirect (priority over everything):
  - Buffer is flushed: count ← 0, pointers reset.
  - pc ← `redirect_pc`.
  - `fetch_fault` and `halted` are cleared.
  - No push and no pop that cycle.
- `out_valid = (count != 0) && !redirect_valid`.
- `out_instr` / `out_pc` are the head entry; they hold their last value when empty and are don't-care then.
- Occupancy update:
  - Push without pop: +1.
  - Pop without push: −1.
  - Both: unchanged. This is legal when full.
- Ordering: strict FIFO; `out_pc` of consecutive pops differs by 4 unless a redirect intervened.

## Timing
- Reset values, applied at the edge where `rst` = 1:
  - pc = `RESET_PC`, count = 0.
  - `out_valid` = 0, `fetch_fault` = 0, `halted` = 0.
  - `inst_addr` = `RESET_PC`.
- `rst` asserted mid-operation discards all buffered entries at that edge, regardless of `redirect_valid` or `out_ready`.
- Latency: one cycle from PC to buffer. First edge with `rst` = 0 pushes `RESET_PC`, and `out_valid` rises after that edge.
- Redirect to first valid output:
  - Redirect at edge N; target pushed at edge N+1; `out_valid` high after edge N+1.
  - The pop that would have occurred in the redirect cycle is suppressed.
- Steady state with `out_ready` held high: one instruction per cycle, no bubbles.
- With `out_ready` low: buffer fills to `DEPTH` in `DEPTH` cycles, then PC stalls. Fetch resumes in the same cycle `out_ready` rises (push + pop when full).
- `fetch_fault` and `halted` are set at the edge of the offending attempt and visible the next cycle. Entries already buffered still drain normally.

## Test plan
- Reset release, memory holding 0x11111111, 0x22222222, 0x33333333 at 0x3000/4/8, `out_ready` = 1:
  - `out_valid` rises one cycle after release.
  - Consecutive pops return (0x3000, 0x11111111), (0x3004, 0x22222222), (0x3008, 0x33333333).
- Backpressure, `out_ready` = 0 for 8 cycles:
  - count saturates at 4 and `inst_addr` holds at 0x3010.
  - Raising `out_ready` yields 0x3000..0x300C, then 0x3010 with no gap.
- Redirect to 0x3020 while the buffer holds 3 entries and `out_ready` = 1:
  - No pop that cycle.
  - Next accepted `out_pc` = 0x3020; the stale entries never appear.
- Redirect to 0x3002 (misaligned):
  - `fetch_fault` = 1 one cycle later; `out_valid` stays 0.
  - Redirect to 0x3000 clears the fault and resumes fetching.
- Sequential run off the end, start at 0x3FF8:
  - Pushes 0x3FF8 and 0x3FFC, then `fetch_fault` = 1.
  - Both entries still drain.
- EOF word (0xFFFFFFFF) at 0x3008:
  - `halted` = 1, 0x3000 and 0x3004 delivered, `inst_addr` stuck at 0x3008.
  - `rst` mid-run clears `halted` and restarts at 0x3000.
